// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the mem_port_arbiter slice: the arbiter state
// encoding, the requester port ids, the rw encoding and the data word returned
// to a requester when the optional memory watchdog fires
// (MEM_ARB_TIMEOUT_EN).
// Ports: none (package).
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  // Round-robin pick. With both ports requesting, the port that did not win
  // last time gets the grant, so neither can be starved.
  function automatic logic pickGrant(input logic i_cpuReq,
                                     input logic i_ldrReq,
                                     input logic i_lastGrant);
    logic w_port;
    if (i_cpuReq && i_ldrReq) begin
      w_port = ~i_lastGrant;
    end else if (i_cpuReq) begin
      w_port = PORT_CPU;
    end else begin
      w_port = PORT_LDR;
    end
    return w_port;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the CPU request port, the loader/debug request port and the memory
// side of the arbiter.
//   cpu_*  : CPU control path (req/rw/addr/wdata in, rdata/moc out)
//   ldr_*  : program loader / debug port (same shape as cpu_*)
//   mem_*  : unified memory (enable/rw/addr/wdata out, rdata/moc in)
// Modports:
//   slave  : the arbiter's view
//   master : the environment's view (requesters plus memory)
// rw encoding: 1 = read, 0 = write.
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              cpu_req;
  logic              cpu_rw;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_moc;

  logic              ldr_req;
  logic              ldr_rw;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic [DATA_W-1:0] ldr_rdata;
  logic              ldr_moc;

  logic              mem_enable;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_moc;

  modport slave (
    input  cpu_req, cpu_rw, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_moc,
    input  ldr_req, ldr_rw, ldr_addr, ldr_wdata,
    output ldr_rdata, ldr_moc,
    output mem_enable, mem_rw, mem_addr, mem_wdata,
    input  mem_rdata, mem_moc
  );

  modport master (
    output cpu_req, cpu_rw, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_moc,
    output ldr_req, ldr_rw, ldr_addr, ldr_wdata,
    input  ldr_rdata, ldr_moc,
    input  mem_enable, mem_rw, mem_addr, mem_wdata,
    output mem_rdata, mem_moc
  );

endinterface

// File: rtl/mem_port_arbiter_watchdog.sv
// -----------------------------------------------------------------------------
// mem_arb_watchdog
// WAIT-state cycle counter for the arbiter. Only built when
// MEM_ARB_TIMEOUT_EN is defined.
// Ports:
//   clk       in  system clock
//   reset     in  synchronous active-high reset
//   i_clear   in  restart the count (arbiter is about to enter WAIT)
//   i_enable  in  arbiter is in WAIT this cycle
//   o_expired out this is the TIMEOUT-th WAIT cycle
// Parameter TIMEOUT (>= 1): number of WAIT cycles allowed.
// -----------------------------------------------------------------------------
`ifdef MEM_ARB_TIMEOUT_EN
module mem_arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  // Counter is never narrower than 8 bits but grows for large TIMEOUT values.
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CNT_W-1:0] r_count;

  // The first WAIT cycle sees a count of 0, so the TIMEOUT-th sees TIMEOUT-1.
  assign o_expired = i_enable && (r_count == CNT_W'(TIMEOUT - 1));

  // Count WAIT cycles; the count restarts from zero every time WAIT is entered.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Two-requester arbiter and handshake sequencer in front of the unified memory
// of the multicycle MIPS core. Port 0 is the CPU control path, port 1 the
// program loader / debug port. Accesses are serialised: grant, drive the
// memory enable/rw/address/data lines, wait for MOC, return the read data and
// a one-cycle MOC pulse to the granted port. All outputs are registered.
// Ports:
//   clk          in  system clock, rising edge
//   reset        in  synchronous active-high reset
//   bus          slave modport of mem_port_arbiter_if (cpu_*, ldr_*, mem_*)
//   timeout_err  out sticky watchdog error (only with MEM_ARB_TIMEOUT_EN)
// Optional feature macro: MEM_ARB_TIMEOUT_EN. When defined, WAIT is abandoned
// after TIMEOUT cycles without MOC and the granted port receives 32'hDEADBEEF.
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 255
`endif
) (
  input logic              clk,
  input logic              reset,
  mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  output logic             timeout_err
`endif
);

  arb_state_t        r_state;
  arb_state_t        w_nextState;

  logic              r_memEnable;
  logic              r_memRw;
  logic [ADDR_W-1:0] r_memAddr;
  logic [DATA_W-1:0] r_memWdata;
  logic [DATA_W-1:0] r_cpuRdata;
  logic [DATA_W-1:0] r_ldrRdata;
  logic              r_cpuMoc;
  logic              r_ldrMoc;
  logic              r_grant;
  logic              r_lastGrant;

  logic              w_grantNow;
  logic              w_grantPort;
  logic              w_captureNow;
  logic [DATA_W-1:0] w_captureData;

`ifdef MEM_ARB_TIMEOUT_EN
  logic              w_wdClear;
  logic              w_wdEnable;
  logic              w_wdExpired;
  logic              w_timeoutHit;
  logic              r_timeoutErr;

  assign w_wdClear  = (r_state == ISSUE);
  assign w_wdEnable = (r_state == WAIT);

  mem_arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_wdClear),
    .i_enable (w_wdEnable),
    .o_expired(w_wdExpired)
  );

  assign timeout_err = r_timeoutErr;
`endif

  assign bus.mem_enable = r_memEnable;
  assign bus.mem_rw     = r_memRw;
  assign bus.mem_addr   = r_memAddr;
  assign bus.mem_wdata  = r_memWdata;
  assign bus.cpu_rdata  = r_cpuRdata;
  assign bus.ldr_rdata  = r_ldrRdata;
  assign bus.cpu_moc    = r_cpuMoc;
  assign bus.ldr_moc    = r_ldrMoc;

  // Next-state logic plus the grant and capture strobes for the datapath.
  // Requests are only looked at in IDLE and MOC only in WAIT; everything the
  // memory sees afterwards comes from the latched registers.
  always_comb begin
    w_nextState   = r_state;
    w_grantNow    = 1'b0;
    w_grantPort   = pickGrant(bus.cpu_req, bus.ldr_req, r_lastGrant);
    w_captureNow  = 1'b0;
    w_captureData = bus.mem_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
    w_timeoutHit  = 1'b0;
`endif

    case (r_state)
      IDLE: begin
        if (bus.cpu_req || bus.ldr_req) begin
          w_grantNow  = 1'b1;
          w_nextState = ISSUE;
        end
      end
      ISSUE: begin
        w_nextState = WAIT;
      end
      WAIT: begin
        if (bus.mem_moc) begin
          w_captureNow = 1'b1;
          w_nextState  = RESP;
`ifdef MEM_ARB_TIMEOUT_EN
        end else if (w_wdExpired) begin
          w_captureNow  = 1'b1;
          w_captureData = DATA_W'(TIMEOUT_DATA);
          w_timeoutHit  = 1'b1;
          w_nextState   = RESP;
`endif
        end
      end
      RESP: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State register and the Moore-style control outputs. The outputs are
  // registered from the next state so they line up with the state they
  // belong to: enable through ISSUE and WAIT, moc only in RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_memEnable <= 1'b0;
      r_cpuMoc    <= 1'b0;
      r_ldrMoc    <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_memEnable <= (w_nextState == ISSUE) || (w_nextState == WAIT);
      r_cpuMoc    <= (w_nextState == RESP) && (r_grant == PORT_CPU);
      r_ldrMoc    <= (w_nextState == RESP) && (r_grant == PORT_LDR);
    end
  end

  // Datapath: latch the winning request on grant and steer returned data to
  // the granted port's rdata register, which holds until that port's next
  // access. last_grant starts at LDR so the CPU wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_memRw     <= RW_WRITE;
      r_memAddr   <= '0;
      r_memWdata  <= '0;
      r_cpuRdata  <= '0;
      r_ldrRdata  <= '0;
      r_grant     <= PORT_CPU;
      r_lastGrant <= PORT_LDR;
    end else begin
      if (w_grantNow) begin
        r_grant     <= w_grantPort;
        r_lastGrant <= w_grantPort;
        if (w_grantPort == PORT_CPU) begin
          r_memRw    <= bus.cpu_rw;
          r_memAddr  <= bus.cpu_addr;
          r_memWdata <= bus.cpu_wdata;
        end else begin
          r_memRw    <= bus.ldr_rw;
          r_memAddr  <= bus.ldr_addr;
          r_memWdata <= bus.ldr_wdata;
        end
      end
      if (w_captureNow) begin
        if (r_grant == PORT_CPU) begin
          r_cpuRdata <= w_captureData;
        end else begin
          r_ldrRdata <= w_captureData;
        end
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  // Sticky error flag: once the watchdog has fired it stays set until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timeoutErr <= 1'b0;
    end else if (w_timeoutHit) begin
      r_timeoutErr <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter. Expected transactions are queued when
// stimulus is issued; a monitor pops and compares them whenever a moc pulse
// appears, and checks the memory-side lines against the queue head while
// mem_enable is high. A simple word memory with programmable MOC delay sits on
// the mem_* side. Build with MEM_ARB_TIMEOUT_EN to also exercise the watchdog.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   typedef struct {
      logic        port;
      logic        rw;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          enCycles;
   } exp_t;

   logic clk = 1'b0;
   logic reset;

   exp_t        expQ[$];
   int          assertCount = 0;
   int          failCount = 0;
   logic [31:0] memArr [0:255];
   int          mocDelay = 1;
   bit          mocStuck = 1'b0;
   int          enCycle = 0;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef MEM_ARB_TIMEOUT_EN
   logic timeout_err;
`endif

   mem_port_arbiter #(
      .ADDR_W(32),
      .DATA_W(32)
`ifdef MEM_ARB_TIMEOUT_EN
      ,
      .TIMEOUT(8)
`endif
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
`ifdef MEM_ARB_TIMEOUT_EN
      ,
      .timeout_err(timeout_err)
`endif
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Memory model: MOC rises once mem_enable has been high for mocDelay edges
   assign bus.mem_moc   = bus.mem_enable && !mocStuck && (enCycle >= mocDelay);
   assign bus.mem_rdata = memArr[bus.mem_addr[9:2]];

   // Memory contents, writes on the MOC edge, and the enable-age counter
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) memArr[i] <= 32'h0;
         memArr[4]  <= 32'h8C22_0004;
         memArr[8]  <= 32'h1111_0020;
         memArr[9]  <= 32'h2222_0024;
         memArr[10] <= 32'h3333_0028;
         memArr[11] <= 32'h4444_002C;
         memArr[20] <= 32'hA5A5_0050;
         enCycle    <= 0;
      end else begin
         enCycle <= bus.mem_enable ? enCycle + 1 : 0;
         if (bus.mem_enable && bus.mem_moc && bus.mem_rw == RW_WRITE)
            memArr[bus.mem_addr[9:2]] <= bus.mem_wdata;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] required);
      assertCount++;
      if (actual !== required) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, required);
      end
   endtask

   // Raise one request, hold it until the port's moc, drop it in the moc cycle
   task automatic driveAccess(input logic port, input logic rw,
                              input logic [31:0] addr, input logic [31:0] wdata);
      bit seen = 1'b0;
      if (port == PORT_CPU) begin
         bus.cpu_rw = rw; bus.cpu_addr = addr; bus.cpu_wdata = wdata; bus.cpu_req = 1'b1;
      end else begin
         bus.ldr_rw = rw; bus.ldr_addr = addr; bus.ldr_wdata = wdata; bus.ldr_req = 1'b1;
      end
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if ((port == PORT_CPU) ? bus.cpu_moc : bus.ldr_moc) begin
            seen = 1'b1;
            break;
         end
      end
      if (port == PORT_CPU) bus.cpu_req = 1'b0;
      else bus.ldr_req = 1'b0;
      if (!seen) begin
         assertCount++;
         failCount++;
         $display("[TB] FAIL handshake: no moc on port %0d for addr %h", port, addr);
      end
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic port, input logic rw,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] expRdata, input int enCycles);
      exp_t e;
      e.port = port; e.rw = rw; e.addr = addr; e.wdata = wdata;
      e.rdata = expRdata; e.enCycles = enCycles;
      expQ.push_back(e);
      driveAccess(port, rw, addr, wdata);
   endtask

   // Monitor: memory-side lines vs queue head while enabled; pop on moc
   initial begin : monitor
      exp_t e;
      bit   prevMoc = 1'b0;
      int   enCnt = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            enCnt = 0;
            prevMoc = 1'b0;
         end else begin
            if (bus.mem_enable) begin
               enCnt++;
               if (expQ.size() > 0) begin
                  checkOutput("mem_addr", bus.mem_addr, expQ[0].addr);
                  checkOutput("mem_rw", 32'(bus.mem_rw), 32'(expQ[0].rw));
                  if (expQ[0].rw == RW_WRITE)
                     checkOutput("mem_wdata", bus.mem_wdata, expQ[0].wdata);
               end
            end
            if (bus.cpu_moc || bus.ldr_moc) begin
               checkOutput("moc exclusive", 32'(bus.cpu_moc & bus.ldr_moc), 32'h0);
               checkOutput("moc pulse width", 32'(prevMoc), 32'h0);
               if (expQ.size() == 0) begin
                  assertCount++;
                  failCount++;
                  $display("[TB] FAIL unexpected moc: cpu_moc=%0d ldr_moc=%0d, expected none",
                           bus.cpu_moc, bus.ldr_moc);
               end else begin
                  e = expQ.pop_front();
                  checkOutput("grant port", 32'(bus.ldr_moc), 32'(e.port));
                  if (e.rw == RW_READ)
                     checkOutput("rdata", bus.ldr_moc ? bus.ldr_rdata : bus.cpu_rdata, e.rdata);
                  checkOutput("enable cycles", 32'(enCnt), 32'(e.enCycles));
               end
               enCnt = 0;
            end
            prevMoc = bus.cpu_moc | bus.ldr_moc;
         end
      end
   end

   // Absolute time limit so the run can never hang
   initial begin
      #1000000;
      $display("[TB] FAIL global time limit: simulation still running, expected finish");
      $fatal(1, "[TB] time limit");
   end

   // Directed test sequence
   initial begin
      exp_t e;
      bus.cpu_req = 1'b0; bus.cpu_rw = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.ldr_req = 1'b0; bus.ldr_rw = 1'b0; bus.ldr_addr = '0; bus.ldr_wdata = '0;
      reset = 1'b1;
      repeat (3) @(negedge clk);

      // Reset state
      checkOutput("rst mem_enable", 32'(bus.mem_enable), 32'h0);
      checkOutput("rst mem_rw", 32'(bus.mem_rw), 32'h0);
      checkOutput("rst mem_addr", bus.mem_addr, 32'h0);
      checkOutput("rst mem_wdata", bus.mem_wdata, 32'h0);
      checkOutput("rst cpu_moc", 32'(bus.cpu_moc), 32'h0);
      checkOutput("rst ldr_moc", 32'(bus.ldr_moc), 32'h0);
      checkOutput("rst cpu_rdata", bus.cpu_rdata, 32'h0);
      checkOutput("rst ldr_rdata", bus.ldr_rdata, 32'h0);
`ifdef MEM_ARB_TIMEOUT_EN
      checkOutput("rst timeout_err", 32'(timeout_err), 32'h0);
`endif
      reset = 1'b0;
      @(negedge clk);

      // Single CPU read, MOC one edge after enable: ISSUE + 1 WAIT = 2 enable cycles
      $display("[TB] single CPU read");
      mocDelay = 1;
      applyStimulus(PORT_CPU, RW_READ, 32'h10, 32'h0, 32'h8C22_0004, 2);
      checkOutput("cpu_rdata held", bus.cpu_rdata, 32'h8C22_0004);

      // Loader write then CPU read-back
      $display("[TB] loader write, CPU read-back");
      applyStimulus(PORT_LDR, RW_WRITE, 32'h40, 32'h1234_5678, 32'h0, 2);
      applyStimulus(PORT_CPU, RW_READ, 32'h40, 32'h0, 32'h1234_5678, 2);

      // Slow memory: MOC on the sixth WAIT cycle -> ISSUE + 6 WAIT = 7
      $display("[TB] slow memory loader read");
      mocDelay = 6;
      applyStimulus(PORT_LDR, RW_READ, 32'h50, 32'h0, 32'hA5A5_0050, 7);
      checkOutput("cpu_rdata untouched by loader", bus.cpu_rdata, 32'h1234_5678);
      mocDelay = 1;

      // Both ports hold requests; last grant was LDR so order is CPU,LDR,CPU,LDR
      $display("[TB] contention round-robin");
      e.rw = RW_READ; e.wdata = 32'h0; e.enCycles = 2;
      e.port = PORT_CPU; e.addr = 32'h20; e.rdata = 32'h1111_0020; expQ.push_back(e);
      e.port = PORT_LDR; e.addr = 32'h24; e.rdata = 32'h2222_0024; expQ.push_back(e);
      e.port = PORT_CPU; e.addr = 32'h28; e.rdata = 32'h3333_0028; expQ.push_back(e);
      e.port = PORT_LDR; e.addr = 32'h2C; e.rdata = 32'h4444_002C; expQ.push_back(e);
      fork
         begin
            driveAccess(PORT_CPU, RW_READ, 32'h20, 32'h0);
            driveAccess(PORT_CPU, RW_READ, 32'h28, 32'h0);
         end
         begin
            driveAccess(PORT_LDR, RW_READ, 32'h24, 32'h0);
            driveAccess(PORT_LDR, RW_READ, 32'h2C, 32'h0);
         end
      join

      // Reset while waiting on memory
      $display("[TB] reset during WAIT");
      mocStuck = 1'b1;
      bus.cpu_rw = RW_READ; bus.cpu_addr = 32'h10; bus.cpu_req = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("enable in WAIT", 32'(bus.mem_enable), 32'h1);
      reset = 1'b1;
      bus.cpu_req = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("enable drop on reset edge", 32'(bus.mem_enable), 32'h0);
      checkOutput("no cpu_moc on reset", 32'(bus.cpu_moc), 32'h0);
      @(negedge clk);
      checkOutput("cpu_rdata cleared", bus.cpu_rdata, 32'h0);
      checkOutput("ldr_rdata cleared", bus.ldr_rdata, 32'h0);
      reset = 1'b0;
      mocStuck = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("idle after reset", 32'(bus.mem_enable), 32'h0);
      applyStimulus(PORT_CPU, RW_READ, 32'h10, 32'h0, 32'h8C22_0004, 2);

`ifdef MEM_ARB_TIMEOUT_EN
      // Memory never answers: 8 WAIT cycles then DEADBEEF -> ISSUE + 8 = 9
      $display("[TB] watchdog timeout");
      mocStuck = 1'b1;
      applyStimulus(PORT_CPU, RW_READ, 32'h10, 32'h0, 32'hDEAD_BEEF, 9);
      checkOutput("timeout_err set", 32'(timeout_err), 32'h1);
      repeat (2) @(negedge clk);
      checkOutput("timeout_err sticky", 32'(timeout_err), 32'h1);
      mocStuck = 1'b0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("timeout_err cleared", 32'(timeout_err), 32'h0);
      reset = 1'b0;
      @(negedge clk);
`endif

      repeat (2) @(negedge clk);
      checkOutput("scoreboard drained", 32'(expQ.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter and handshake sequencer in front of the single unified memory of the multicycle MIPS core.
- Requester 0 is the CPU control path (its memEnable/rw/MAR/MDR signals). Requester 1 is a program loader/debug port that preloads and inspects memory while the core runs.
- Serialises accesses, drives the memory enable/rw/address/data lines, waits for MOC, and returns data plus a per-port MOC pulse.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, WAIT-state cycle limit. Used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request; hold until cpu_moc.
- cpu_rw  in  1  1 = read, 0 = write.
- cpu_addr  in  ADDR_W  CPU address (MAR).
- cpu_wdata  in  DATA_W  CPU write data (MDR).
- cpu_rdata  out  DATA_W  read data, valid while cpu_moc = 1.
- cpu_moc  out  1  one-cycle completion pulse to CPU.
- ldr_req  in  1  loader request; hold until ldr_moc.
- ldr_rw  in  1  1 = read, 0 = write.
- ldr_addr  in  ADDR_W  loader address.
- ldr_wdata  in  DATA_W  loader write data.
- ldr_rdata  out  DATA_W  read data, valid while ldr_moc = 1.
- ldr_moc  out  1  one-cycle completion pulse to loader.
- mem_enable  out  1  memory enable.
- mem_rw  out  1  memory direction, same encoding as the ports.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- mem_moc  in  1  memory operation complete.

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high on port `reset`.
- Reset values: state = IDLE. mem_enable, mem_rw, cpu_moc and ldr_moc = 0. mem_addr, mem_wdata, cpu_rdata and ldr_rdata = 0. last_grant = LDR, so the CPU wins the first tie.
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE, no request: stay in IDLE.
- IDLE, one request: grant that port.
- IDLE, both requests: round-robin; grant the port that is not last_grant.
  - On grant, latch rw/addr/wdata into the mem_* registers, record the grant, set last_grant, go to ISSUE.
- ISSUE: mem_enable = 1; go to WAIT.
- WAIT: mem_enable held at 1; latched signals stay stable.
  - On mem_moc = 1 (sampled): capture mem_rdata into the granted port's rdata register (writes also capture it; harmless), drop mem_enable, go to RESP.
- RESP: granted port's moc = 1 for exactly one cycle; go to IDLE.
- Latency: req sampled at edge N; mem_enable high from N+1. With a combinational MOC, moc is high in cycle N+3. Back-to-back grants are possible from the next IDLE.
- Request hold rule: a requester deasserts req in the cycle moc is high. A req still high at the next IDLE edge is a new request.
- rdata registers hold their value until overwritten by the next access to that port.
- mem_moc outside WAIT is ignored.
- Port inputs change only while idle; the arbiter copes regardless because it uses only latched values.
- Reset mid-operation: the next edge returns to IDLE and mem_enable drops that edge. No moc pulse is emitted.
- No starvation: a continuously requesting port is served at least every second transaction.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- When defined:
  - Adds output timeout_err (1 bit) and an 8-bit-min counter cleared on entry to WAIT.
  - If TIMEOUT cycles elapse in WAIT with no mem_moc: go to RESP with granted rdata = 32'hDEAD_BEEF; timeout_err set sticky until reset.
- When undefined: no port, no counter; WAIT waits indefinitely.

Decomposition:
- Package mem_arb_pkg contains:
  - the state enum (IDLE/ISSUE/WAIT/RESP),
  - port-id constants PORT_CPU = 0 and PORT_LDR = 1,
  - RW_READ = 1 and RW_WRITE = 0,
  - TIMEOUT_DATA = 32'hDEAD_BEEF.
- One natural sub-module: mem_arb_watchdog (counter + compare), instantiated only under MEM_ARB_TIMEOUT_EN.

Test Plan:
- Single CPU read, addr 0x10, memory model returns 0x8C220004 with MOC one cycle after enable → cpu_moc pulses once; cpu_rdata = 0x8C220004; ldr_moc stays 0.
- Loader write, addr 0x40, data 0x12345678, then CPU read of 0x40 → mem_rw = 0 during the write; CPU read returns 0x12345678.
- Both requests asserted simultaneously and held for 4 transactions → grant order CPU, LDR, CPU, LDR; exactly one moc per transaction.
- Memory delays MOC by 5 cycles → mem_enable and mem_addr stay constant for all 6 WAIT cycles; moc is a single-cycle pulse.
- reset asserted during WAIT → mem_enable = 0 at the next edge; no moc pulse; a fresh CPU request afterwards completes normally.
- MEM_ARB_TIMEOUT_EN with TIMEOUT = 8 and MOC never asserted → after 8 WAIT cycles cpu_moc pulses, cpu_rdata = 0xDEADBEEF, timeout_err = 1 until reset.
